game_ctrl: RTL and testbench

Top-level game sequencer for the space-invaders datapath. Owns the play/respawn/wave-clear/game-over state machine, drives the score/lives tracker's synchronous reset, requests invader-wave reloads, freezes gameplay during transitions, and optionally records a high score. It sits between the button inputs and the score, invader and player blocks, and is paced by the one-pulse-per-frame tick.

---
 rtl/game_ctrl_pkg.sv | 26 ++
 rtl/game_ctrl_frame_timer.sv | 38 +++
 rtl/game_ctrl.sv | 143 ++++++++++++++
 tb/tb_game_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared constants for the game sequencer: state encodings, field widths, lives count.
// HUD and renderer import this so they decode `state` the same way.
package game_ctrl_pkg;

  localparam int unsigned STATE_W      = 3;
  localparam int unsigned WAVE_W       = 4;
  localparam int unsigned SCORE_W      = 7;
  localparam int unsigned LIVES_W      = 2;
  localparam int unsigned INV_W        = 6;
  localparam int unsigned PLAYER_LIVES = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_PLAY       = 3'd2,
    ST_RESPAWN    = 3'd3,
    ST_WAVE_CLEAR = 3'd4,
    ST_GAME_OVER  = 3'd5
  } state_e;

  // States that run the frame timer
  function automatic logic is_timed(state_e s);
    return (s == ST_RESPAWN) || (s == ST_WAVE_CLEAR);
  endfunction

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// Tick-driven frame counter: held at zero while disabled, done_c fires on the terminal tick.
module game_ctrl_frame_timer #(
  parameter int unsigned CNT_W     = 7,
  parameter int unsigned BLINK_BIT = 3
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             blink_o,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_c  = en_i && tick_i && (cnt_q == last_i);
  assign blink_o = cnt_q[BLINK_BIT];

  // Clearing on done keeps the counter from ever wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || done_c) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: play/respawn/wave-clear/game-over FSM with score and wave reset pulses.
// Optional high-score register enabled by GAME_CTRL_HIGH_SCORE_EN.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned RESPAWN_FRAMES = 120,
  parameter int unsigned CLEAR_FRAMES   = 90,
  parameter int unsigned BLINK_LOG2     = 3,
  parameter int unsigned MAX_WAVE       = 15
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               player_collision,
  input  logic [LIVES_W-1:0] lives,
  input  logic [SCORE_W-1:0] score,
  input  logic [INV_W-1:0]   invaders_left,
  output logic [STATE_W-1:0] state,
  output logic               score_rst,
  output logic               wave_rst,
  output logic               freeze,
  output logic               player_visible,
  output logic [WAVE_W-1:0]  wave,
  output logic [SCORE_W-1:0] high_score
);

  localparam int unsigned MAX_FRAMES = (RESPAWN_FRAMES > CLEAR_FRAMES) ? RESPAWN_FRAMES : CLEAR_FRAMES;
  localparam int unsigned CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  state_e              state_q, state_d;
  logic                btn_q;
  logic                score_rst_q, score_rst_d;
  logic                wave_rst_q, wave_rst_d;
  logic [WAVE_W-1:0]   wave_q, wave_d;
  logic                start_edge;
  logic                blink;
  logic                done_c;
  logic [CNT_W-1:0]    last;

  assign start_edge = start_btn && !btn_q;
  assign last = (state_q == ST_WAVE_CLEAR) ? CNT_W'(CLEAR_FRAMES - 1) : CNT_W'(RESPAWN_FRAMES - 1);

  game_ctrl_frame_timer #(
    .CNT_W     (CNT_W),
    .BLINK_BIT (BLINK_LOG2)
  ) u_frame_timer (
    .clk     (clk),
    .arst_n  (arst_n),
    .en_i    (is_timed(state_q)),
    .tick_i  (frame_tick),
    .last_i  (last),
    .blink_o (blink),
    .done_c  (done_c)
  );

  always_comb begin
    state_d = state_q;
    wave_d  = wave_q;
    case (state_q)
      ST_IDLE:      if (start_edge) state_d = ST_START;
      ST_START:     state_d = ST_PLAY;
      ST_PLAY: begin
        if (player_collision && (lives <= LIVES_W'(1))) state_d = ST_GAME_OVER;
        else if (lives == '0)                           state_d = ST_GAME_OVER;
        else if (player_collision)                      state_d = ST_RESPAWN;
        else if (invaders_left == '0)                   state_d = ST_WAVE_CLEAR;
      end
      ST_RESPAWN:   if (done_c) state_d = ST_PLAY;
      ST_WAVE_CLEAR: begin
        if (done_c) begin
          state_d = ST_PLAY;
          if (wave_q < WAVE_W'(MAX_WAVE)) wave_d = wave_q + WAVE_W'(1);
        end
      end
      ST_GAME_OVER: if (start_edge) state_d = ST_START;
      default:      state_d = ST_IDLE;
    endcase
    if (state_d == ST_START) wave_d = WAVE_W'(1);
    score_rst_d = (state_d == ST_START);
    wave_rst_d  = (state_d == ST_START) || ((state_q == ST_WAVE_CLEAR) && done_c);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      btn_q       <= 1'b0;
      score_rst_q <= 1'b0;
      wave_rst_q  <= 1'b0;
      wave_q      <= '0;
    end else begin
      state_q     <= state_d;
      btn_q       <= start_btn;
      score_rst_q <= score_rst_d;
      wave_rst_q  <= wave_rst_d;
      wave_q      <= wave_d;
    end
  end

  // Sprite and freeze decode straight from registered state and counter
  always_comb begin
    player_visible = 1'b0;
    case (state_q)
      ST_PLAY, ST_WAVE_CLEAR: player_visible = 1'b1;
      ST_RESPAWN:             player_visible = !blink;
      default:                player_visible = 1'b0;
    endcase
  end

  assign freeze    = (state_q != ST_PLAY);
  assign state     = state_q;
  assign score_rst = score_rst_q;
  assign wave_rst  = wave_rst_q;
  assign wave      = wave_q;

`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [SCORE_W-1:0] hs_q, hs_d;
  logic               go_q;

  // Sample score once, on the first cycle spent in GAME_OVER
  always_comb begin
    hs_d = hs_q;
    if ((state_q == ST_GAME_OVER) && !go_q && (score > hs_q)) hs_d = score;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hs_q <= '0;
      go_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      go_q <= (state_q == ST_GAME_OVER);
    end
  end

  assign high_score = hs_q;
`else
  logic unused_score_c;
  assign unused_score_c = ^score;
  assign high_score     = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: scenario tasks with randomized tick spacing and scores.
`timescale 1ns/1ps
module tb_game_ctrl;

  localparam int RESPAWN = 120;
  localparam int CLEAR   = 90;
  localparam int BLINK   = 8;
  localparam int MAXW    = 15;
  localparam int S_IDLE = 0, S_START = 1, S_PLAY = 2, S_RESPAWN = 3, S_CLEAR = 4, S_OVER = 5;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       player_collision = 1'b0;
  logic [1:0] lives = 2'd3;
  logic [6:0] score = 7'd0;
  logic [5:0] invaders_left = 6'd40;
  logic [2:0] state;
  logic       score_rst, wave_rst, freeze, player_visible;
  logic [3:0] wave;
  logic [6:0] high_score;

  int checks = 0;
  int errors = 0;
  int wave_model = 0;
  int hs_model = 0;

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .frame_tick       (frame_tick),
    .start_btn        (start_btn),
    .player_collision (player_collision),
    .lives            (lives),
    .score            (score),
    .invaders_left    (invaders_left),
    .state            (state),
    .score_rst        (score_rst),
    .wave_rst         (wave_rst),
    .freeze           (freeze),
    .player_visible   (player_visible),
    .wave             (wave),
    .high_score       (high_score)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
    end
  endtask

  task automatic new_game();
    start_btn = 1'b1; step(); step();
    start_btn = 1'b0; step();
    wave_model = 1;
  endtask

  function automatic int hs_after(input int prev, input int sc);
`ifdef GAME_CTRL_HIGH_SCORE_EN
    return (sc > prev) ? sc : prev;
`else
    return 0;
`endif
  endfunction

  task automatic test_reset();
    arst_n = 1'b0; step(); step();
    checks++; if (state !== 3'(S_IDLE)) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state, S_IDLE); end
    checks++; if (score_rst !== 1'b0 || wave_rst !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", score_rst, wave_rst); end
    checks++; if (freeze !== 1'b1 || player_visible !== 1'b0) begin errors++; $display("FAIL reset_freeze_vis got=%b%b exp=10", freeze, player_visible); end
    checks++; if (wave !== 4'd0 || high_score !== 7'd0) begin errors++; $display("FAIL reset_wave_hs got=%0d/%0d exp=0/0", wave, high_score); end
    arst_n = 1'b1; step();
    checks++; if (state !== 3'(S_IDLE)) begin errors++; $display("FAIL idle_hold got=%0d exp=%0d", state, S_IDLE); end
  endtask

  task automatic test_start();
    lives = 2'd3; invaders_left = 6'($urandom_range(1, 55));
    start_btn = 1'b1; step();
    wave_model = 1;
    checks++; if (state !== 3'(S_START)) begin errors++; $display("FAIL start_state got=%0d exp=%0d", state, S_START); end
    checks++; if (score_rst !== 1'b1 || wave_rst !== 1'b1) begin errors++; $display("FAIL start_pulses got=%b%b exp=11", score_rst, wave_rst); end
    checks++; if (freeze !== 1'b1 || player_visible !== 1'b0) begin errors++; $display("FAIL start_freeze_vis got=%b%b exp=10", freeze, player_visible); end
    step();
    checks++; if (state !== 3'(S_PLAY)) begin errors++; $display("FAIL play_state got=%0d exp=%0d", state, S_PLAY); end
    checks++; if (score_rst !== 1'b0 || wave_rst !== 1'b0) begin errors++; $display("FAIL play_pulses got=%b%b exp=00", score_rst, wave_rst); end
    checks++; if (wave !== 4'(wave_model) || freeze !== 1'b0 || player_visible !== 1'b1) begin errors++; $display("FAIL play_outputs got wave=%0d fz=%b vis=%b exp wave=%0d fz=0 vis=1", wave, freeze, player_visible, wave_model); end
    start_btn = 1'b0; step();
  endtask

  task automatic test_respawn();
    lives = 2'($urandom_range(2, 3)); invaders_left = 6'($urandom_range(1, 55));
    player_collision = 1'b1; step(); player_collision = 1'b0;
    checks++; if (state !== 3'(S_RESPAWN) || freeze !== 1'b1) begin errors++; $display("FAIL resp_entry got st=%0d fz=%b exp st=%0d fz=1", state, freeze, S_RESPAWN); end
    for (int k = 0; k < RESPAWN; k++) begin
      repeat ($urandom_range(0, 2)) begin
        player_collision = ($urandom_range(0, 7) == 0); step();
      end
      player_collision = 1'b0;
      checks++; if (state !== 3'(S_RESPAWN)) begin errors++; $display("FAIL resp_hold tick=%0d got=%0d exp=%0d", k, state, S_RESPAWN); end
      checks++; if (player_visible !== (((k / BLINK) % 2) == 0)) begin errors++; $display("FAIL resp_blink tick=%0d got=%b exp=%b", k, player_visible, ((k / BLINK) % 2) == 0); end
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
    end
    checks++; if (state !== 3'(S_PLAY) || freeze !== 1'b0 || player_visible !== 1'b1) begin errors++; $display("FAIL resp_exit got st=%0d fz=%b vis=%b exp st=%0d fz=0 vis=1", state, freeze, player_visible, S_PLAY); end
    checks++; if (wave !== 4'(wave_model)) begin errors++; $display("FAIL resp_wave got=%0d exp=%0d", wave, wave_model); end
  endtask

  task automatic test_wave_clear();
    int pulses;
    for (int i = 0; i < MAXW; i++) begin
      lives = 2'd3; invaders_left = 6'd0; step();
      checks++; if (state !== 3'(S_CLEAR) || player_visible !== 1'b1 || freeze !== 1'b1) begin errors++; $display("FAIL clr_entry i=%0d got st=%0d vis=%b fz=%b", i, state, player_visible, freeze); end
      pulses = 0;
      for (int k = 0; k < CLEAR; k++) begin
        repeat ($urandom_range(0, 1)) begin step(); if (wave_rst) pulses++; end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        if (wave_rst) pulses++;
      end
      invaders_left = 6'($urandom_range(1, 55));
      wave_model = (wave_model + 1 > MAXW) ? MAXW : wave_model + 1;
      checks++; if (state !== 3'(S_PLAY)) begin errors++; $display("FAIL clr_exit i=%0d got=%0d exp=%0d", i, state, S_PLAY); end
      checks++; if (wave !== 4'(wave_model)) begin errors++; $display("FAIL clr_wave i=%0d got=%0d exp=%0d", i, wave, wave_model); end
      step();
      if (wave_rst) pulses++;
      checks++; if (pulses !== 1) begin errors++; $display("FAIL clr_pulses i=%0d got=%0d exp=1", i, pulses); end
    end
  endtask

  task automatic test_simultaneous();
    lives = 2'd3; invaders_left = 6'd0; player_collision = 1'b1; step();
    player_collision = 1'b0; invaders_left = 6'($urandom_range(1, 55));
    checks++; if (state !== 3'(S_RESPAWN)) begin errors++; $display("FAIL simul_state got=%0d exp=%0d", state, S_RESPAWN); end
    run_ticks(RESPAWN);
    checks++; if (state !== 3'(S_PLAY)) begin errors++; $display("FAIL simul_exit got=%0d exp=%0d", state, S_PLAY); end
  endtask

  task automatic test_fatal();
    int sc;
    lives = 2'd1; score = 7'd42; player_collision = 1'b1; step();
    player_collision = 1'b0; lives = 2'd0;
    checks++; if (state !== 3'(S_OVER) || freeze !== 1'b1 || player_visible !== 1'b0) begin errors++; $display("FAIL fatal_state got st=%0d fz=%b vis=%b exp st=%0d fz=1 vis=0", state, freeze, player_visible, S_OVER); end
    step(); step();
    hs_model = hs_after(hs_model, 42);
    checks++; if (high_score !== 7'(hs_model)) begin errors++; $display("FAIL hs_first got=%0d exp=%0d", high_score, hs_model); end
    lives = 2'd3; score = 7'd0; new_game();
    checks++; if (high_score !== 7'(hs_model)) begin errors++; $display("FAIL hs_after_score_rst got=%0d exp=%0d", high_score, hs_model); end
    score = 7'd30; lives = 2'd0; step();
    checks++; if (state !== 3'(S_OVER)) begin errors++; $display("FAIL lives0_state got=%0d exp=%0d", state, S_OVER); end
    step(); step();
    hs_model = hs_after(hs_model, 30);
    checks++; if (high_score !== 7'(hs_model)) begin errors++; $display("FAIL hs_lower got=%0d exp=%0d", high_score, hs_model); end
    lives = 2'd3; score = 7'd0; new_game();
    sc = $urandom_range(43, 99); score = 7'(sc);
    lives = 2'd1; player_collision = 1'b1; step(); player_collision = 1'b0; lives = 2'd0;
    step(); step();
    hs_model = hs_after(hs_model, sc);
    checks++; if (high_score !== 7'(hs_model)) begin errors++; $display("FAIL hs_higher got=%0d exp=%0d", high_score, hs_model); end
  endtask

  task automatic test_held_button();
    int starts;
    int srst;
    lives = 2'd3; invaders_left = 6'($urandom_range(1, 55));
    start_btn = 1'b1; starts = 0; srst = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (state == 3'(S_START)) starts++;
      if (score_rst) srst++;
    end
    wave_model = 1;
    checks++; if (starts !== 1 || srst !== 1) begin errors++; $display("FAIL held_starts got=%0d/%0d exp=1/1", starts, srst); end
    checks++; if (state !== 3'(S_PLAY) || wave !== 4'(wave_model)) begin errors++; $display("FAIL held_play got st=%0d wave=%0d exp st=%0d wave=%0d", state, wave, S_PLAY, wave_model); end
    lives = 2'd1; player_collision = 1'b1; step(); player_collision = 1'b0; lives = 2'd0;
    repeat (10) step();
    checks++; if (state !== 3'(S_OVER)) begin errors++; $display("FAIL held_over got=%0d exp=%0d", state, S_OVER); end
    start_btn = 1'b0; step();
  endtask

  task automatic test_reset_mid_respawn();
    lives = 2'd3; invaders_left = 6'($urandom_range(1, 55)); new_game();
    player_collision = 1'b1; step(); player_collision = 1'b0;
    run_ticks($urandom_range(10, 60));
    checks++; if (state !== 3'(S_RESPAWN)) begin errors++; $display("FAIL mid_pre got=%0d exp=%0d", state, S_RESPAWN); end
    #2 arst_n = 1'b0; #1;
    hs_model = 0;
    checks++; if (state !== 3'(S_IDLE) || wave !== 4'd0) begin errors++; $display("FAIL mid_reset got st=%0d wave=%0d exp st=%0d wave=0", state, wave, S_IDLE); end
    checks++; if (freeze !== 1'b1 || player_visible !== 1'b0 || high_score !== 7'(hs_model)) begin errors++; $display("FAIL mid_reset_out got fz=%b vis=%b hs=%0d exp fz=1 vis=0 hs=%0d", freeze, player_visible, high_score, hs_model); end
    repeat (3) step();
    checks++; if (score_rst !== 1'b0 || wave_rst !== 1'b0 || state !== 3'(S_IDLE)) begin errors++; $display("FAIL mid_hold got st=%0d pulses=%b%b exp st=0 pulses=00", state, score_rst, wave_rst); end
    arst_n = 1'b1; step(); step();
    checks++; if (state !== 3'(S_IDLE)) begin errors++; $display("FAIL mid_release got=%0d exp=%0d", state, S_IDLE); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_respawn();
    test_wave_clear();
    test_simultaneous();
    test_fatal();
    test_held_button();
    test_reset_mid_respawn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
